muldiv_unit: RTL

- Parametrised, iterative multiply/divide unit that owns the architectural HI/LO registers.
- Supersedes single-cycle HI/LO handling in the pipeline.
- Sits beside the EX-stage ALU. The controller issues MULT/MULTU/DIV/DIVU with a start pulse. The hazard unit stalls on busy when MFHI/MFLO or a new mul/div reaches EX.
- Also serves MTHI/MTLO direct writes.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_div_step.sv | 21 ++
 rtl/muldiv_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Includes operation and state encodings, the default iterative latency, and op decode helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_t;

    localparam int MULDIV_WIDTH    = 32;
    localparam int MULDIV_LAT_ITER = MULDIV_WIDTH + 1;

    function automatic logic op_is_signed(input op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_mul(input op_t op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: subtract the divisor from the shifted partial
// remainder when it fits, producing the next remainder and one quotient bit.
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   part_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] diff;

    always_comb begin
        diff  = part_i - {1'b0, divisor_i};
        q_o   = (part_i >= {1'b0, divisor_i});
        // When the divisor does not fit, part_i < divisor so its top bit is zero.
        rem_o = q_o ? diff[WIDTH-1:0] : part_i[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Optional single-cycle multiply path selected by defining MULDIV_FAST_MUL_EN.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    input  logic             hiwe,
    input  logic             lowe,
    input  logic [WIDTH-1:0] hlwd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t               state_q;
    op_t                  op_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]     opb_q;
    logic [WIDTH-1:0]     srca_q;
    logic                 neg_res_q;
    logic                 neg_rem_q;
    logic                 div0_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic [WIDTH-1:0]     hi_d;
    logic [WIDTH-1:0]     lo_d;
    logic                 done_q;

    op_t                  op_in;
    logic                 sgn_in;
    logic                 a_neg;
    logic                 b_neg;
    logic                 mul_in;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic                 is_mul;
    logic                 run_last;

    logic [WIDTH:0]       div_part;
    logic [WIDTH-1:0]     div_rem;
    logic                 div_q;

    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign op_in = op_t'(op);

    always_comb begin
        sgn_in = op_is_signed(op_in);
        mul_in = op_is_mul(op_in);
        a_neg  = sgn_in & srca[WIDTH-1];
        b_neg  = sgn_in & srcb[WIDTH-1];
        a_abs  = a_neg ? (-srca) : srca;
        b_abs  = b_neg ? (-srcb) : srcb;
    end

    assign is_mul = op_is_mul(op_q);

    // Divide layout: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    assign div_part = acc_q[2*WIDTH-1:WIDTH-1];

    muldiv_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .part_i    (div_part),
        .divisor_i (opb_q),
        .rem_o     (div_rem),
        .q_o       (div_q)
    );

`ifdef MULDIV_FAST_MUL_EN
    assign run_last = is_mul | (cnt_q == '0);

    always_comb begin
        acc_d = acc_q;
        if (is_mul) begin
            acc_d = {{WIDTH{1'b0}}, opb_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
        end else begin
            acc_d = {div_rem, acc_q[WIDTH-2:0], div_q};
        end
    end
`else
    logic [WIDTH:0] mul_sum;

    assign run_last = (cnt_q == '0);

    // Multiply layout: acc = {partial product, multiplier bits not yet consumed}.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        acc_d   = acc_q;
        if (is_mul) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
            acc_d = {div_rem, acc_q[WIDTH-2:0], div_q};
        end
    end
`endif

    // Most-negative / -1 needs no special case: the magnitude quotient already
    // equals the most-negative bit pattern and the sign flags cancel.
    always_comb begin
        prod_fix = neg_res_q ? (-acc_q) : acc_q;
        quot_fix = neg_res_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        hi_d     = rem_fix;
        lo_d     = quot_fix;
        if (is_mul) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
        end else if (div0_q) begin
            hi_d = srca_q;
            lo_d = {WIDTH{1'b1}};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_MULT;
            acc_q     <= '0;
            opb_q     <= '0;
            srca_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (hiwe) begin
                hi_q <= hlwd;
            end
            if (lowe) begin
                lo_q <= hlwd;
            end
            case (state_q)
                S_IDLE: begin
                    if (start && !flush) begin
                        state_q   <= S_RUN;
                        op_q      <= op_in;
                        opb_q     <= mul_in ? a_abs : b_abs;
                        acc_q     <= {{WIDTH{1'b0}}, (mul_in ? b_abs : a_abs)};
                        srca_q    <= srca;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        div0_q    <= (srcb == '0);
                        cnt_q     <= CNT_W'(WIDTH - 1);
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (run_last) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    // Completion overrides any same-cycle MTHI/MTLO write.
                    if (!flush) begin
                        hi_q   <= hi_d;
                        lo_q   <= lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
